// File: rtl/feature_loader.sv
// Serial-to-parallel feature loader with a one-deep shift buffer, a valid/ready output slot and a held vector.
// Optional even-parity frame check is enabled by defining FEATURE_LOADER_PARITY_EN.
module feature_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [WIDTH-1:0] vec_hold,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef FEATURE_LOADER_PARITY_EN
    localparam int FLEN   = WIDTH + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FLEN   = WIDTH;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CW = $clog2(FLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_par, w_par_nxt;
    logic [WIDTH-1:0] r_vec, w_vec_nxt;
    logic             r_vld, w_vld_nxt;
    logic [WIDTH-1:0] r_hold;
    logic             r_busy;
    logic             r_ovr, w_ovr;
    logic             r_perr, w_perr;

    logic             w_take;
    logic             w_slot_free;
    logic [WIDTH-1:0] w_base_sh;
    logic [CW-1:0]    w_base_cnt;
    logic             w_base_par;
    logic             w_data_bit;
    logic [WIDTH-1:0] w_frame;
    logic             w_par_ok;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
        if (MSB_FIRST)
            return {base[WIDTH-2:0], b};
        else
            return {b, base[WIDTH-1:1]};
    endfunction

    assign w_take      = r_vld && vec_ready;
    assign w_slot_free = !r_vld || vec_ready;

    // A frame_start restarts assembly from an empty shift register in the same cycle
    assign w_base_sh  = frame_start ? '0 : r_sh;
    assign w_base_cnt = frame_start ? '0 : r_cnt;
    assign w_base_par = frame_start ? 1'b0 : r_par;
    assign w_data_bit = (w_base_cnt < CW'(WIDTH));

    // The trailing parity bit is never shifted into the vector
    assign w_frame  = w_data_bit ? shift_in(w_base_sh, ser_in) : w_base_sh;
    assign w_par_ok = !PAR_EN || ((w_base_par ^ ser_in) == 1'b0);

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_vec_nxt   = r_vec;
        w_vld_nxt   = w_take ? 1'b0 : r_vld;
        w_ovr       = 1'b0;
        w_perr      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nxt = S_SHIFT;
                    w_sh_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_par_nxt   = 1'b0;
                    if (ser_valid) begin
                        w_sh_nxt  = shift_in('0, ser_in);
                        w_cnt_nxt = CW'(1);
                        w_par_nxt = ser_in;
                    end
                end
            end

            S_SHIFT: begin
                w_sh_nxt  = w_base_sh;
                w_cnt_nxt = w_base_cnt;
                w_par_nxt = w_base_par;
                if (ser_valid) begin
                    w_sh_nxt  = w_frame;
                    w_cnt_nxt = w_base_cnt + CW'(1);
                    if (w_data_bit)
                        w_par_nxt = w_base_par ^ ser_in;
                    if (w_base_cnt == CW'(FLEN - 1)) begin
                        w_cnt_nxt = '0;
                        if (!w_par_ok) begin
                            w_perr      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else if (w_slot_free) begin
                            w_vec_nxt   = w_frame;
                            w_vld_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_FULL;
                        end
                    end
                end
            end

            S_FULL: begin
                // Completed frame parked in the shift register until the slot drains
                if (ser_valid || frame_start)
                    w_ovr = 1'b1;
                if (w_take) begin
                    w_vec_nxt   = r_sh;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_vec   <= '0;
            r_vld   <= 1'b0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_vec   <= w_vec_nxt;
            r_vld   <= w_vld_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_ovr   <= w_ovr;
            r_perr  <= w_perr;
            if (w_take)
                r_hold <= r_vec;
        end
    end

    assign vec_out    = r_vec;
    assign vec_valid  = r_vld;
    assign vec_hold   = r_hold;
    assign busy       = r_busy;
    assign overrun    = r_ovr;
    assign parity_err = r_perr;

endmodule

// File: tb/tb_feature_loader.sv
// Directed self-checking bench for feature_loader (WIDTH=8, MSB_FIRST=1).
// Parity scenarios run only when FEATURE_LOADER_PARITY_EN is defined.
module tb_feature_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic [7:0] vec_out;
    logic       vec_valid;
    logic       vec_ready = 1'b0;
    logic [7:0] vec_hold;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_count  = 0;
    int ovr_count = 0;

    feature_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .ser_in(ser_in),
        .ser_valid(ser_valid), .vec_out(vec_out), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .vec_hold(vec_hold), .busy(busy),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vec_valid && vec_ready) hs_count <= hs_count + 1;
        if (overrun) ovr_count <= ovr_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        ser_valid = 1'b1; ser_in = b; frame_start = fs;
        tick();
        ser_valid = 1'b0; ser_in = 1'b0; frame_start = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // frame_start cycle, then data MSB first, then even parity when enabled
    task automatic send_frame(input logic [7:0] v);
        pulse_start();
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
`ifdef FEATURE_LOADER_PARITY_EN
        send_bit(^v, 1'b0);
`endif
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        n_tests++; if (vec_out !== 8'h00 || vec_valid !== 1'b0 || vec_hold !== 8'h00) begin n_fail++; $display("FAIL reset_init: out=%h vld=%b hold=%h required 00/0/00", vec_out, vec_valid, vec_hold); end
        pulse_start();
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_midframe: got %b required 1", busy); end
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_tests++; if (vec_out !== 8'h00 || vec_valid !== 1'b0 || vec_hold !== 8'h00) begin n_fail++; $display("FAIL reset_mid_data: out=%h vld=%b hold=%h required 00/0/00", vec_out, vec_valid, vec_hold); end
        n_tests++; if (busy !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ctrl: busy=%b ovr=%b perr=%b required 0/0/0", busy, overrun, parity_err); end
        pulse_start();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        send_bit(0, 0); send_bit(0, 0); send_bit(1, 0);
        n_tests++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b required 0", vec_valid); end
        send_bit(0, 0);
`ifdef FEATURE_LOADER_PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        n_tests++; if (vec_valid !== 1'b1 || vec_out !== 8'hB2) begin n_fail++; $display("FAIL first_frame: vld=%b out=%h required 1/b2", vec_valid, vec_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b required 0", busy); end
    endtask

    task automatic test_handshake();
        vec_ready = 1'b0;
        send_bit(1'b1, 1'b0);
        n_tests++; if (vec_out !== 8'hB2 || busy !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL idle_bit_ignored: out=%h busy=%b ovr=%b required b2/0/0", vec_out, busy, overrun); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (vec_out !== 8'hB2 || vec_valid !== 1'b1 || vec_hold !== 8'h00) begin n_fail++; $display("FAIL stall_%0d: out=%h vld=%b hold=%h required b2/1/00", i, vec_out, vec_valid, vec_hold); end
        end
        vec_ready = 1'b1; tick(); vec_ready = 1'b0;
        n_tests++; if (vec_hold !== 8'hB2 || vec_valid !== 1'b0) begin n_fail++; $display("FAIL accept: hold=%h vld=%b required b2/0", vec_hold, vec_valid); end
    endtask

    task automatic test_backpressure();
        int ovr0;
        vec_ready = 1'b0;
        send_frame(8'hB2);
        send_frame(8'h5A);
        n_tests++; if (busy !== 1'b1 || vec_out !== 8'hB2 || vec_valid !== 1'b1) begin n_fail++; $display("FAIL enter_full: busy=%b out=%h vld=%b required 1/b2/1", busy, vec_out, vec_valid); end
        ovr0 = ovr_count;
        send_bit(1'b1, 1'b0);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %b required 1", overrun); end
        tick();
        n_tests++; if (overrun !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL overrun_clear: ovr=%b busy=%b required 0/1", overrun, busy); end
        n_tests++; if (ovr_count - ovr0 !== 1) begin n_fail++; $display("FAIL overrun_count: got %0d required 1", ovr_count - ovr0); end
        vec_ready = 1'b1; tick();
        n_tests++; if (vec_out !== 8'h5A || vec_valid !== 1'b1 || vec_hold !== 8'hB2 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_full: out=%h vld=%b hold=%h busy=%b required 5a/1/b2/0", vec_out, vec_valid, vec_hold, busy); end
        tick(); vec_ready = 1'b0;
        n_tests++; if (vec_hold !== 8'h5A || vec_valid !== 1'b0) begin n_fail++; $display("FAIL drain_second: hold=%h vld=%b required 5a/0", vec_hold, vec_valid); end
    endtask

    task automatic test_streaming();
        int hs0, ov0;
        logic [7:0] vals [3];
        vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'hFF;
        hs0 = hs_count; ov0 = ovr_count;
        vec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_frame(vals[k]);
            n_tests++; if (vec_valid !== 1'b1 || vec_out !== vals[k]) begin n_fail++; $display("FAIL stream_%0d: vld=%b out=%h required 1/%h", k, vec_valid, vec_out, vals[k]); end
        end
        tick();
        vec_ready = 1'b0;
        n_tests++; if (vec_hold !== 8'hFF || vec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_hold: hold=%h vld=%b required ff/0", vec_hold, vec_valid); end
        n_tests++; if (hs_count - hs0 !== 3 || ovr_count - ov0 !== 0) begin n_fail++; $display("FAIL stream_counts: hs=%0d ovr=%0d required 3/0", hs_count - hs0, ovr_count - ov0); end
    endtask

    task automatic test_restart();
        logic [7:0] v;
        v = 8'hC3;
        vec_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_bit(v[7], 1'b1);
        n_tests++; if (busy !== 1'b1 || vec_valid !== 1'b0) begin n_fail++; $display("FAIL restart_busy: busy=%b vld=%b required 1/0", busy, vec_valid); end
        for (int i = 6; i >= 1; i--) send_bit(v[i], 1'b0);
        n_tests++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL restart_early: vld=%b required 0", vec_valid); end
        send_bit(v[0], 1'b0);
`ifdef FEATURE_LOADER_PARITY_EN
        send_bit(^v, 1'b0);
`endif
        n_tests++; if (vec_valid !== 1'b1 || vec_out !== 8'hC3) begin n_fail++; $display("FAIL restart_frame: vld=%b out=%h required 1/c3", vec_valid, vec_out); end
        vec_ready = 1'b1; tick(); vec_ready = 1'b0;
        n_tests++; if (vec_hold !== 8'hC3 || vec_valid !== 1'b0) begin n_fail++; $display("FAIL restart_accept: hold=%h vld=%b required c3/0", vec_hold, vec_valid); end
    endtask

`ifdef FEATURE_LOADER_PARITY_EN
    task automatic test_parity();
        vec_ready = 1'b0;
        pulse_start();
        for (int i = 7; i >= 0; i--) send_bit(i < 2, 1'b0);
        send_bit(1'b0, 1'b0);
        n_tests++; if (vec_valid !== 1'b1 || vec_out !== 8'h03 || parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good: vld=%b out=%h perr=%b required 1/03/0", vec_valid, vec_out, parity_err); end
        vec_ready = 1'b1; tick(); vec_ready = 1'b0;
        pulse_start();
        for (int i = 7; i >= 0; i--) send_bit(i < 2, 1'b0);
        send_bit(1'b1, 1'b0);
        n_tests++; if (parity_err !== 1'b1 || vec_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL parity_bad: perr=%b vld=%b busy=%b required 1/0/0", parity_err, vec_valid, busy); end
        tick();
        n_tests++; if (parity_err !== 1'b0 || vec_hold !== 8'h03) begin n_fail++; $display("FAIL parity_clear: perr=%b hold=%h required 0/03", parity_err, vec_hold); end
    endtask
`else
    task automatic test_parity();
        send_frame(8'h03);
        n_tests++; if (parity_err !== 1'b0 || vec_out !== 8'h03) begin n_fail++; $display("FAIL parity_off: perr=%b out=%h required 0/03", parity_err, vec_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_handshake();
        test_backpressure();
        test_streaming();
        test_restart();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
